// File: rtl/data_memory_pkg.sv
// Shared types for the data_memory block: FSM states, request kinds, fixed widths.
// Ports: none (package only).
// Imported by data_memory_if, data_memory and sram_bytelane.
package common;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_t;

  // Value loaded into the latency counter at acceptance; zero means the
  // response follows the acceptance cycle directly.
  function automatic logic [CNT_W-1:0] latency_load(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus between an initiator and data_memory.
// Ports: address, read_enable/read_data/read_valid, write_data/write_enable/
// write_wstrb/write_ready, access_fault. master = initiator, slave = memory.
interface data_memory_if;
  import common::*;

  logic [WORD_W-1:0] address;
  logic              read_enable;
  logic [WORD_W-1:0] read_data;
  logic              read_valid;
  logic [WORD_W-1:0] write_data;
  logic              write_enable;
  logic [LANES-1:0]  write_wstrb;
  logic              write_ready;
  logic              access_fault;

  modport master (
    output address, read_enable, write_data, write_enable, write_wstrb,
    input  read_data, read_valid, write_ready, access_fault
  );

  modport slave (
    input  address, read_enable, write_data, write_enable, write_wstrb,
    output read_data, read_valid, write_ready, access_fault
  );

endinterface

// File: rtl/data_memory_sram_bytelane.sv
// Word storage as four independent byte lanes with per-lane write enables.
// Ports: clock/reset, registered read port (rd_en, rd_zero, rd_idx -> rd_word),
// write port (lane_we, wr_idx, wr_word). Reset clears only the read register.
module sram_bytelane
  import common::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [AW-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_word,
  input  logic [LANES-1:0]  lane_we,
  input  logic [AW-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_word
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    // Array kept out of the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
      if (lane_we[i]) begin
        mem[wr_idx] <= wr_word[8*i +: 8];
      end
    end

    // Read register only loads on rd_en, so it holds between reads.
    // rd_zero forces a zero word (used for out-of-range reads).
    always_ff @(posedge clock) begin
      if (reset) begin
        q <= '0;
      end else if (rd_en) begin
        q <= rd_zero ? 8'h00 : mem[rd_idx];
      end
    end

    assign rd_word[8*i +: 8] = q;
  end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency word memory: requests accepted in IDLE, answered LATENCY cycles later.
// Ports: clock, reset (sync, active-high), bus (data_memory_if.slave).
// Requests are level-held; dropping both enables during BUSY aborts the access.
module data_memory
  import common::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic          clock,
  input logic          reset,
  data_memory_if.slave bus
);

  localparam int              IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = latency_load(LATENCY);

  state_t            state;
  req_t              req_type;
  logic [CNT_W-1:0]  count;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [LANES-1:0]  wstrb_q;
  logic              read_valid_q;
  logic              write_ready_q;
  logic              fault_q;

  logic              req_any;
  logic              accept;
  logic              enter_resp;
  logic              enter_read;
  logic              enter_fault;
  logic              in_fault;
  logic              lat_fault;
  logic [IDX_W-1:0]  in_idx;
  logic [IDX_W-1:0]  lat_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_en;
  logic [LANES-1:0]  lane_we;
  logic [WORD_W-1:0] rd_word;

  // Byte-offset bits never take part in indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[1:0], addr_q[1:0]};

  assign req_any   = bus.read_enable | bus.write_enable;
  assign accept    = (state == IDLE) && req_any;
  assign in_idx    = bus.address[IDX_W+1:2];
  assign lat_idx   = addr_q[IDX_W+1:2];
  assign in_fault  = |(bus.address >> (IDX_W + 2));
  assign lat_fault = |(addr_q >> (IDX_W + 2));

  // The edge that moves the FSM into RESP. With LATENCY=1 this is the
  // acceptance edge itself, so request fields come straight from the bus;
  // otherwise it is the last BUSY edge and latched fields are used.
  assign enter_resp  = (accept && (CNT_LOAD == '0)) ||
                       ((state == BUSY) && req_any && (count == CNT_W'(1)));
  assign enter_read  = (state == IDLE) ? !bus.write_enable : (req_type == REQ_READ);
  assign enter_fault = (state == IDLE) ? in_fault : lat_fault;
  assign rd_idx      = (state == IDLE) ? in_idx : lat_idx;

  // Read data is captured on the RESP entry edge so read_data only changes
  // together with read_valid and otherwise keeps its last value.
  assign rd_en = enter_resp && enter_read && !reset;

  // Writes commit at the end of the RESP cycle; faults and reset drop them.
  assign lane_we = ((state == RESP) && (req_type == REQ_WRITE) && !lat_fault && !reset)
                   ? wstrb_q : '0;

  sram_bytelane #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_sram (
    .clock   (clock),
    .reset   (reset),
    .rd_en   (rd_en),
    .rd_zero (enter_fault),
    .rd_idx  (rd_idx),
    .rd_word (rd_word),
    .lane_we (lane_we),
    .wr_idx  (lat_idx),
    .wr_word (wdata_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      req_type      <= REQ_READ;
      count         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      read_valid_q  <= 1'b0;
      write_ready_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      read_valid_q  <= enter_resp && enter_read;
      write_ready_q <= enter_resp && !enter_read;
      fault_q       <= enter_resp && enter_fault;
      case (state)
        IDLE: begin
          if (req_any) begin
            addr_q   <= bus.address;
            wdata_q  <= bus.write_data;
            wstrb_q  <= bus.write_wstrb;
            req_type <= bus.write_enable ? REQ_WRITE : REQ_READ;
            count    <= CNT_LOAD;
            state    <= (CNT_LOAD == '0) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (!req_any) begin
            // Initiator withdrew: abandon silently.
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.read_data    = rd_word;
  assign bus.read_valid   = read_valid_q;
  assign bus.write_ready  = write_ready_q;
  assign bus.access_fault = fault_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory (LATENCY=2/DEPTH=1024 main instance, LATENCY=1/DEPTH=16 second).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_data_memory;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  data_memory_if bus();
  data_memory_if bus1();

  data_memory #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  data_memory #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  int total = 0;
  int bad   = 0;

  // Performs one access on the main instance; returns negedges from drive to
  // completion (capped at 20) and the observed response.
  task automatic xact(input logic do_wr, input logic also_rd, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, output int cyc,
                      output logic rv, output logic wr, output logic [31:0] rdat,
                      output logic flt);
    @(negedge clock);
    bus.address = a; bus.write_data = d; bus.write_wstrb = s;
    bus.write_enable = do_wr; bus.read_enable = !do_wr || also_rd;
    cyc = 0; rv = 0; wr = 0; rdat = '0; flt = 0;
    while (!(rv || wr) && cyc < 20) begin
      @(negedge clock); cyc++;
      rv = bus.read_valid; wr = bus.write_ready; rdat = bus.read_data; flt = bus.access_fault;
    end
    bus.read_enable = 1'b0; bus.write_enable = 1'b0;
  endtask

  task automatic xact1(input logic do_wr, input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output logic rv, output logic wr,
                       output logic [31:0] rdat, output logic flt);
    @(negedge clock);
    bus1.address = a; bus1.write_data = d; bus1.write_wstrb = 4'hF;
    bus1.write_enable = do_wr; bus1.read_enable = !do_wr;
    cyc = 0; rv = 0; wr = 0; rdat = '0; flt = 0;
    while (!(rv || wr) && cyc < 20) begin
      @(negedge clock); cyc++;
      rv = bus1.read_valid; wr = bus1.write_ready; rdat = bus1.read_data; flt = bus1.access_fault;
    end
    bus1.read_enable = 1'b0; bus1.write_enable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (bus.read_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b want 0", bus.read_valid); end
    total++; if (bus.write_ready !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", bus.write_ready); end
    total++; if (bus.access_fault !== 1'b0) begin bad++; $display("FAIL reset_flt: got %b want 0", bus.access_fault); end
    total++; if (bus.read_data !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.read_data); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_read_latency();
    int cyc; logic rv, wr, flt; logic [31:0] rd;
    xact(1, 0, 32'h0C, 32'hDEADBEEF, 4'hF, cyc, rv, wr, rd, flt);
    total++; if (!(wr && cyc == 2)) begin bad++; $display("FAIL preload_wr: ready=%b cyc=%0d want 1/2", wr, cyc); end
    xact(0, 0, 32'h0C, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (!rv || cyc !== 2) begin bad++; $display("FAIL rd_latency: valid=%b cyc=%0d want 1/2", rv, cyc); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    total++; if (flt !== 1'b0) begin bad++; $display("FAIL rd_fault: got %b want 0", flt); end
    repeat (2) @(negedge clock);
    total++; if (bus.read_valid !== 1'b0 || bus.read_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rd_hold: valid=%b data=%h want 0/deadbeef", bus.read_valid, bus.read_data);
    end
  endtask

  task automatic test_strobe();
    int cyc; logic rv, wr, flt; logic [31:0] rd;
    xact(1, 0, 32'h10, 32'h11223344, 4'hF, cyc, rv, wr, rd, flt);
    xact(1, 0, 32'h10, 32'hAABBCCDD, 4'b0101, cyc, rv, wr, rd, flt);
    total++; if (!wr || rv || flt) begin bad++; $display("FAIL strb_wr: ready=%b valid=%b flt=%b want 1/0/0", wr, rv, flt); end
    xact(0, 0, 32'h10, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strb_data: got %h want 11bb33dd", rd); end
    xact(1, 0, 32'h10, 32'hFFFFFFFF, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (!wr || cyc !== 2) begin bad++; $display("FAIL strb0_wr: ready=%b cyc=%0d want 1/2", wr, cyc); end
    xact(0, 0, 32'h10, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL strb0_data: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic got;
    @(negedge clock);
    bus.address = 32'h20; bus.write_data = 32'h5; bus.write_wstrb = 4'hF;
    bus.write_enable = 1'b1; bus.read_enable = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin @(negedge clock); cyc++; got = bus.write_ready; end
    total++; if (cyc !== 2) begin bad++; $display("FAIL b2b_wr_cyc: got %0d want 2", cyc); end
    bus.write_enable = 1'b0; bus.read_enable = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin @(negedge clock); cyc++; got = bus.read_valid; end
    // One IDLE acceptance cycle, then the normal two-cycle latency.
    total++; if (cyc !== 3) begin bad++; $display("FAIL b2b_rd_cyc: got %0d want 3", cyc); end
    total++; if (bus.read_data !== 32'h5) begin bad++; $display("FAIL b2b_data: got %h want 5", bus.read_data); end
    bus.read_enable = 1'b0;
  endtask

  task automatic test_busy_inputs();
    int cyc; logic rv, wr, flt, got; logic [31:0] rd;
    xact(1, 0, 32'h34, 32'h55AA55AA, 4'hF, cyc, rv, wr, rd, flt);
    @(negedge clock);
    bus.address = 32'h30; bus.write_data = 32'h01020304; bus.write_wstrb = 4'hF; bus.write_enable = 1'b1;
    @(negedge clock);
    bus.address = 32'h34; bus.write_data = 32'hFFFFFFFF;
    cyc = 1; got = 0;
    while (!got && cyc < 20) begin @(negedge clock); cyc++; got = bus.write_ready; end
    bus.write_enable = 1'b0;
    xact(0, 0, 32'h30, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL busy_latched: got %h want 01020304", rd); end
    xact(0, 0, 32'h34, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'h55AA55AA) begin bad++; $display("FAIL busy_other: got %h want 55aa55aa", rd); end
  endtask

  task automatic test_both_enables();
    int cyc; logic rv, wr, flt; logic [31:0] rd;
    xact(1, 1, 32'h38, 32'h77, 4'hF, cyc, rv, wr, rd, flt);
    total++; if (!wr || rv) begin bad++; $display("FAIL both_kind: ready=%b valid=%b want 1/0", wr, rv); end
    xact(0, 0, 32'h38, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'h77) begin bad++; $display("FAIL both_data: got %h want 77", rd); end
  endtask

  task automatic test_abort();
    int cyc; logic got;
    @(negedge clock);
    bus.address = 32'h0C; bus.read_enable = 1'b1;
    @(negedge clock);
    total++; if (bus.read_valid !== 1'b0) begin bad++; $display("FAIL abort_busy: valid=%b want 0", bus.read_valid); end
    bus.read_enable = 1'b0;
    @(negedge clock);
    total++; if (bus.read_valid !== 1'b0) begin bad++; $display("FAIL abort_pulse: valid=%b want 0", bus.read_valid); end
    // Immediate new request: accepted at once only if the FSM is in IDLE.
    bus.address = 32'h10; bus.read_enable = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 20) begin @(negedge clock); cyc++; got = bus.read_valid; end
    total++; if (cyc !== 2) begin bad++; $display("FAIL abort_idle: cyc=%0d want 2", cyc); end
    total++; if (bus.read_data !== 32'h11BB33DD) begin bad++; $display("FAIL abort_next: got %h want 11bb33dd", bus.read_data); end
    bus.read_enable = 1'b0;
  endtask

  task automatic test_out_of_range();
    int cyc; logic rv, wr, flt; logic [31:0] rd;
    xact(1, 0, 32'h0, 32'hCAFEF00D, 4'hF, cyc, rv, wr, rd, flt);
    xact(0, 0, 32'h0, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    xact(1, 0, 32'h1000, 32'h12345678, 4'hF, cyc, rv, wr, rd, flt);
    total++; if (!wr || !flt || cyc !== 2) begin bad++; $display("FAIL oor_wr: ready=%b flt=%b cyc=%0d want 1/1/2", wr, flt, cyc); end
    xact(0, 0, 32'h1000, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (!rv || !flt) begin bad++; $display("FAIL oor_rd: valid=%b flt=%b want 1/1", rv, flt); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL oor_rdata: got %h want 0", rd); end
    xact(0, 0, 32'h0, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'hCAFEF00D || flt !== 1'b0) begin bad++; $display("FAIL oor_word0: got %h flt=%b want cafef00d/0", rd, flt); end
  endtask

  task automatic test_reset_mid_write();
    int cyc; logic rv, wr, flt, seen; logic [31:0] rd;
    xact(1, 0, 32'h04, 32'h0BADF00D, 4'hF, cyc, rv, wr, rd, flt);
    xact(0, 0, 32'h04, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    @(negedge clock);
    bus.address = 32'h04; bus.write_data = 32'hFFFFFFFF; bus.write_wstrb = 4'hF; bus.write_enable = 1'b1;
    @(negedge clock);
    reset = 1'b1; bus.write_enable = 1'b0;
    @(negedge clock);
    total++; if (bus.read_data !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.read_data); end
    seen = bus.write_ready;
    reset = 1'b0;
    repeat (4) begin @(negedge clock); seen = seen | bus.write_ready; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_ready: seen=%b want 0", seen); end
    xact(0, 0, 32'h04, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL rst_word1: got %h want 0badf00d", rd); end
    xact(0, 0, 32'h0C, 32'h0, 4'h0, cyc, rv, wr, rd, flt);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rst_keep_mem: got %h want deadbeef", rd); end
  endtask

  task automatic test_latency_one();
    int cyc; logic rv, wr, flt; logic [31:0] rd;
    xact1(1, 32'h08, 32'h1234ABCD, cyc, rv, wr, rd, flt);
    total++; if (!wr || cyc !== 1) begin bad++; $display("FAIL l1_wr: ready=%b cyc=%0d want 1/1", wr, cyc); end
    xact1(0, 32'h08, 32'h0, cyc, rv, wr, rd, flt);
    total++; if (!rv || cyc !== 1) begin bad++; $display("FAIL l1_rd: valid=%b cyc=%0d want 1/1", rv, cyc); end
    total++; if (rd !== 32'h1234ABCD) begin bad++; $display("FAIL l1_data: got %h want 1234abcd", rd); end
    xact1(0, 32'h40, 32'h0, cyc, rv, wr, rd, flt);
    total++; if (!flt || rd !== 32'h0) begin bad++; $display("FAIL l1_oor: flt=%b data=%h want 1/0", flt, rd); end
  endtask

  initial begin
    reset = 1'b1;
    bus.address = '0; bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    bus.write_data = '0; bus.write_wstrb = '0;
    bus1.address = '0; bus1.read_enable = 1'b0; bus1.write_enable = 1'b0;
    bus1.write_data = '0; bus1.write_wstrb = '0;
    test_reset();
    test_read_latency();
    test_strobe();
    test_back_to_back();
    test_busy_inputs();
    test_both_enables();
    test_abort();
    test_out_of_range();
    test_reset_mid_write();
    test_latency_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; must be a power of two.
REQ-002 SHALL have parameter LATENCY, default 2: response delay in cycles; legal range 1..15.
REQ-003 SHALL have port clock, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port address, input, 32: byte address; bits [1:0] ignored for indexing.
REQ-006 SHALL have port read_enable, input, 1: level read request, held by the initiator until read_valid.
REQ-007 SHALL have port read_data, output, 32: read word, meaningful only while read_valid=1.
REQ-008 SHALL have port read_valid, output, 1: one-cycle read completion pulse.
REQ-009 SHALL have port write_data, input, 32: store data, byte-aligned to lanes.
REQ-010 SHALL have port write_enable, input, 1: level write request, held until write_ready.
REQ-011 SHALL have port write_wstrb, input, 4: byte-lane enables; bit i enables write_data[8i+7:8i].
REQ-012 SHALL have port write_ready, output, 1: one-cycle write completion pulse.
REQ-013 SHALL have port access_fault, output, 1: one-cycle pulse, coincident with completion, for an out-of-range access.

Function
REQ-014 SHALL implement the FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-015 IDLE: if read_enable or write_enable is sampled high, SHALL latch address, write_data, write_wstrb and the request type, load counter=LATENCY-1, then go to BUSY (counter 0 -> RESP directly).
REQ-016 BUSY: SHALL decrement the counter each cycle and enter RESP when it reaches 0.
REQ-017 The response SHALL be asserted exactly LATENCY cycles after the acceptance cycle (LATENCY=1 -> the next cycle).
REQ-018 RESP, read: SHALL assert read_valid=1 for one cycle with read_data = mem[latched index].
REQ-019 RESP, write: SHALL assert write_ready=1 for one cycle, committing only the strobed bytes at the end of that cycle.
REQ-020 RESP -> IDLE SHALL be unconditional.
REQ-021 A request still held in the cycle after RESP SHALL be treated as a new request (back-to-back accesses); no bubble beyond the IDLE acceptance cycle.
REQ-022 If the request deasserts (both enables low) while in BUSY, SHALL abort to IDLE: no response pulse, no memory update.
REQ-023 If read_enable and write_enable are both high at acceptance, SHALL treat the access as a write.
REQ-024 The index SHALL be address[log2(DEPTH_WORDS)+1:2].
REQ-025 Address range: any nonzero bit above the index field SHALL be out of range.
REQ-026 Out-of-range read: SHALL return read_data=0 with read_valid=1 and access_fault=1.
REQ-027 Out-of-range write: SHALL drop the write, with write_ready=1 and access_fault=1.
REQ-028 write_wstrb=0 SHALL complete normally with no memory change.
REQ-029 Inputs changing during BUSY SHALL be ignored; latched values govern the access.
REQ-030 read_data SHALL hold its last value outside read_valid.

Reset
REQ-031 On reset, SHALL set state=IDLE, counter=0, read_valid=0, write_ready=0, access_fault=0, read_data=0.
REQ-032 Reset mid-access SHALL cancel the access with no memory update and no response pulse.
REQ-033 Memory array contents SHALL NOT be cleared by reset.

Structure
REQ-034 The state enum (IDLE, BUSY, RESP) and the request-type enum (REQ_READ, REQ_WRITE) SHALL live in the shared package common.
REQ-035 Storage SHALL be a sub-module sram_bytelane: 4 byte-wide lanes, with one registered read port and a per-lane write enable.
REQ-036 The counter width SHALL be 4 bits.

Verification
REQ-037 Read latency: preload word 3=0xDEADBEEF, LATENCY=2, hold read_enable with address=0x0C -> read_valid pulses exactly 2 cycles after acceptance, read_data=0xDEADBEEF.
REQ-038 Strobed write: write 0xAABBCCDD with wstrb=0b0101 to 0x10 over old value 0x11223344 -> write_ready pulse; a later read returns 0x11BB33DD.
REQ-039 Back-to-back: write 0x5 to 0x20, then immediately read 0x20 -> second acceptance in the cycle after write_ready; read returns 0x5.
REQ-040 Abort: drop read_enable in the first BUSY cycle -> no read_valid; FSM back in IDLE next cycle.
REQ-041 Out of range: with DEPTH_WORDS=1024, write then read at 0x00001000 -> both pulse access_fault; read_data=0; word 0 unchanged.
REQ-042 Reset mid-write: assert reset during BUSY of a write to 0x04 -> no write_ready; word 1 keeps its old value.
